// File: rtl/toggle_mon_pkg.sv
// toggle_mon_pkg: shared state type and default parameters for the toggle period monitor.
package toggle_mon_pkg;
    typedef enum logic [1:0] {SEEK, HIGH, LOW} tm_state_t;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 1000;
endpackage

// File: rtl/toggle_period_monitor_bit_sync.sv
// bit_sync: multi-flop synchronizer for a single asynchronous bit, cleared to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_sh;
    always_ff @(posedge clk)
        r_sh <= clr ? '0 : {r_sh[STAGES-2:0], d};
    assign q = r_sh[STAGES-1];
endmodule

// File: rtl/toggle_period_monitor.sv
// toggle_period_monitor: measures high/low run lengths of a toggling input and reports each period over valid/ready.
module toggle_period_monitor
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tog_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_drop,
    output logic             stall
);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    tm_state_t        r_state, w_state_nx;
    logic [CNT_W-1:0] r_run, w_run_nx, r_hi_lat, w_hi_nx, r_high, r_low;
    logic [SW-1:0]    r_settle;
    logic w_lvl, r_lvl_d, w_rise, w_fall, w_tmo, w_done, w_load, w_settled;
    logic r_armed, w_armed_nx, r_stall, w_stall_nx, r_valid, r_drop;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .clr(clr), .d(tog_in), .q(w_lvl));

    assign w_rise    = w_lvl & ~r_lvl_d;
    assign w_fall    = ~w_lvl & r_lvl_d;
    // lvl only reflects tog_in once the cleared synchronizer has flushed; arming
    // before then would count a high level that was already present at reset.
    assign w_settled = r_settle == SW'(SYNC_STAGES);
    assign w_tmo     = r_run == CNT_W'(TIMEOUT);
    assign w_done    = r_state == LOW && w_rise;
    assign w_load    = w_done && (!r_valid || meas_ready);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= SEEK;
            r_run    <= '0;
            r_hi_lat <= '0;
            r_settle <= '0;
            r_lvl_d  <= 1'b0;
            r_armed  <= 1'b0;
            r_stall  <= 1'b0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
            r_high   <= '0;
            r_low    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_run    <= w_run_nx;
            r_hi_lat <= w_hi_nx;
            r_settle <= w_settled ? r_settle : r_settle + SW'(1);
            r_lvl_d  <= w_lvl;
            r_armed  <= w_armed_nx;
            r_stall  <= w_stall_nx;
            r_valid  <= w_load | (r_valid & ~meas_ready);
            r_drop   <= w_done & r_valid & ~meas_ready;
            if (w_load) begin
                r_high <= r_hi_lat;
                r_low  <= r_run;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_run_nx   = r_run;
        w_hi_nx    = r_hi_lat;
        w_stall_nx = r_stall;
        w_armed_nx = r_armed | (~w_lvl & w_settled);
        case (r_state)
            SEEK: if (w_rise && r_armed) begin
                w_state_nx = HIGH;
                w_run_nx   = CNT_W'(1);
                w_stall_nx = 1'b0;
            end
            HIGH: if (w_fall) begin
                w_hi_nx    = r_run;
                w_run_nx   = CNT_W'(1);
                w_state_nx = LOW;
            end else if (w_tmo) begin
                w_state_nx = SEEK;
                w_stall_nx = 1'b1;
                w_armed_nx = 1'b0;
            end else if (w_lvl) w_run_nx = r_run + CNT_W'(1);
            LOW: if (w_rise) begin
                w_run_nx   = CNT_W'(1);
                w_state_nx = HIGH;
            end else if (w_tmo) begin
                w_state_nx = SEEK;
                w_stall_nx = 1'b1;
                w_armed_nx = 1'b0;
            end else if (!w_lvl) w_run_nx = r_run + CNT_W'(1);
            default: w_state_nx = SEEK;
        endcase
    end

    assign meas_valid = r_valid;
    assign meas_high  = r_high;
    assign meas_low   = r_low;
    assign meas_drop  = r_drop;
    assign stall      = r_stall;
endmodule

// File: tb/tb_toggle_period_monitor.sv
// tb_toggle_period_monitor: directed cycle-accurate checks of the toggle period monitor.
module tb_toggle_period_monitor;
    import toggle_mon_pkg::*;
    logic        clk = 1'b0, clr = 1'b1, tog_in = 1'b1, meas_ready = 1'b0;
    logic        meas_valid, meas_drop, stall;
    logic [15:0] meas_high, meas_low;
    int          checks = 0, failures = 0;

    toggle_period_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
        .clk(clk), .clr(clr), .tog_in(tog_in), .meas_valid(meas_valid), .meas_ready(meas_ready),
        .meas_high(meas_high), .meas_low(meas_low), .meas_drop(meas_drop), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_meas(input string tag, input logic v, input logic [15:0] h, input logic [15:0] l);
        chk({tag, "_valid"}, 32'(meas_valid), 32'(v));
        chk({tag, "_high"}, 32'(meas_high), 32'(h));
        chk({tag, "_low"}, 32'(meas_low), 32'(l));
    endtask

    initial begin
        // reset held with input high: everything quiet
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk_meas("rst", 1'b0, 16'd0, 16'd0);
            chk("rst_drop", 32'(meas_drop), 0);
            chk("rst_stall", 32'(stall), 0);
        end
        clr = 1'b0;
        cyc(8);
        chk("rel_state", 32'(dut.r_state), 32'(SEEK));
        chk("rel_valid", 32'(meas_valid), 0);
        tog_in = 1'b0;
        cyc(5);
        chk("arm_state", 32'(dut.r_state), 32'(SEEK));
        // basic 3 high / 5 low
        meas_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tog_in = 1'b1;
            cyc(2);
            chk("basic_early", 32'(meas_valid), 0);
            cyc(1);
            if (i > 0) chk_meas("basic", 1'b1, 16'd3, 16'd5);
            else chk("basic_first", 32'(meas_valid), 0);
            tog_in = 1'b0;
            cyc(1);
            chk("basic_drain", 32'(meas_valid), 0);
            cyc(4);
        end
        // toggling every clock
        for (int k = 0; k < 16; k++) begin
            int q;
            tog_in = (k % 2 == 0);
            cyc(1);
            q = k + 1;
            chk("tff_drop", 32'(meas_drop), 0);
            chk("tff_valid", 32'(meas_valid), 32'(q >= 3 && q % 2 == 1));
            if (q == 3) chk_meas("tff_prev", 1'b1, 16'd3, 16'd5);
            if (q >= 5 && q % 2 == 1) chk_meas("tff", 1'b1, 16'd1, 16'd1);
        end
        cyc(3);
        // backpressure on a 2/2 pattern
        for (int j = 0; j < 16; j++) begin
            int q;
            tog_in = ((j / 2) % 2 == 0);
            meas_ready = (j == 14);
            cyc(1);
            q = j + 1;
            chk("bp_valid", 32'(meas_valid), 32'(q >= 3));
            chk("bp_drop", 32'(meas_drop), 32'(q == 7 || q == 11));
            if (q >= 15) chk_meas("bp_new", 1'b1, 16'd2, 16'd2);
            else if (q >= 3) chk_meas("bp_hold", 1'b1, 16'd1, 16'd4);
        end
        // stall: high held past TIMEOUT
        meas_ready = 1'b1;
        tog_in = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            cyc(1);
            chk("stall_lvl", 32'(stall), 32'(t >= 13));
            if (t == 3) chk_meas("stall_prev", 1'b1, 16'd2, 16'd2);
        end
        chk("stall_state", 32'(dut.r_state), 32'(SEEK));
        chk("stall_valid", 32'(meas_valid), 0);
        tog_in = 1'b0;
        cyc(3);
        tog_in = 1'b1;
        for (int t = 24; t <= 26; t++) begin
            cyc(1);
            chk("unstall", 32'(stall), 32'(t < 26));
            chk("unstall_valid", 32'(meas_valid), 0);
        end
        tog_in = 1'b0;
        cyc(4);
        chk("nopartial", 32'(meas_valid), 0);
        // mid-operation reset while holding a result in LOW
        meas_ready = 1'b0;
        tog_in = 1'b1;
        cyc(2);
        tog_in = 1'b0;
        cyc(1);
        chk_meas("pre_clr", 1'b1, 16'd3, 16'd4);
        cyc(3);
        chk("pre_clr_state", 32'(dut.r_state), 32'(LOW));
        chk("pre_clr_valid", 32'(meas_valid), 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk_meas("clr", 1'b0, 16'd0, 16'd0);
        chk("clr_stall", 32'(stall), 0);
        chk("clr_drop", 32'(meas_drop), 0);
        meas_ready = 1'b1;
        cyc(3);
        tog_in = 1'b1;
        cyc(4);
        tog_in = 1'b0;
        cyc(6);
        tog_in = 1'b1;
        cyc(2);
        chk("fresh_early", 32'(meas_valid), 0);
        cyc(1);
        chk_meas("fresh", 1'b1, 16'd4, 16'd6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
